// File: rtl/hash_lookup_ctrl_if.sv
// Bundle of header, search-engine, aging and forwarding signals around the
// MAC-table front end. The master view is the controller; the slave view is
// everything around it (header parser, hash bucket, forwarding stage).
interface hash_lookup_ctrl_if;
  // Parsed header in
  logic        hdr_valid;
  logic        hdr_ready;
  logic [47:0] hdr_dmac;
  logic [47:0] hdr_smac;
  logic [3:0]  hdr_port;

  // Search-engine request/response
  logic        se_source;
  logic [47:0] se_mac;
  logic [15:0] se_portmap;
  logic [9:0]  se_hash;
  logic        se_req;
  logic        se_ack;
  logic        se_nak;
  logic [15:0] se_result;

  // Aging sweep pacing
  logic        aging_req;
  logic        aging_ack;

  // Forwarding result
  logic        fwd_valid;
  logic [15:0] fwd_portmap;
  logic        fwd_hit;
  logic [15:0] learn_fail_cnt;

  modport master (
    input  hdr_valid, hdr_dmac, hdr_smac, hdr_port,
    output hdr_ready,
    output se_source, se_mac, se_portmap, se_hash, se_req,
    input  se_ack, se_nak, se_result,
    output aging_req,
    input  aging_ack,
    output fwd_valid, fwd_portmap, fwd_hit, learn_fail_cnt
  );

  modport slave (
    output hdr_valid, hdr_dmac, hdr_smac, hdr_port,
    input  hdr_ready,
    input  se_source, se_mac, se_portmap, se_hash, se_req,
    output se_ack, se_nak, se_result,
    input  aging_req,
    output aging_ack,
    input  fwd_valid, fwd_portmap, fwd_hit, learn_fail_cnt
  );
endinterface

// File: rtl/hash_lookup_ctrl.sv
// MAC-table front end: takes one parsed header, learns the SMAC, looks up the
// DMAC in the 2-way hash bucket and emits the egress portmap. Also paces the
// periodic aging sweeps of the table independently of header traffic.
module hash_lookup_ctrl #(
  parameter logic [15:0] PORT_MASK    = 16'hFFFF,
  parameter logic [5:0]  SE_TIMEOUT   = 6'd32,
  parameter logic [31:0] AGING_PERIOD = 32'd125000000
) (
  input logic                clk,
  input logic                rstn,
  hash_lookup_ctrl_if.master io_bus
);

  typedef enum logic [2:0] {
    StIdle,
    StLearn,
    StGap,
    StLookup,
    StDone
  } state_e;

  // Last cycle of the bucket response window and of the aging idle period.
  localparam logic [5:0]  TmoLast = SE_TIMEOUT - 6'd1;
  localparam logic [31:0] AgeLast = AGING_PERIOD - 32'd1;

  // Bucket index: XOR fold of the MAC in 10-bit slices, top slice zero-padded.
  function automatic logic [9:0] mac_hash(input logic [47:0] m);
    return m[9:0] ^ m[19:10] ^ m[29:20] ^ m[39:30] ^ {2'b00, m[47:40]};
  endfunction

  state_e      r_state;
  state_e      w_state_nxt;

  logic [47:0] r_dmac;
  logic [47:0] r_smac;
  logic [15:0] r_src_bit;
  logic [9:0]  r_hash_s;
  logic [9:0]  r_hash_d;

  logic [5:0]  r_tmo_cnt;
  logic [5:0]  w_tmo_cnt_nxt;
  logic        r_se_req;
  logic        r_hdr_ready;

  logic        r_fwd_valid;
  logic [15:0] r_fwd_portmap;
  logic [15:0] w_fwd_portmap_nxt;
  logic        r_fwd_hit;
  logic        w_fwd_hit_nxt;
  logic [15:0] r_fail_cnt;
  logic [15:0] w_fail_cnt_nxt;

  logic        r_aging_req;
  logic        w_aging_req_nxt;
  logic [31:0] r_age_cnt;
  logic [31:0] w_age_cnt_nxt;

  logic        w_hdr_xfer;
  logic        w_tmo;
  logic        w_resp_fail;
  logic [9:0]  w_hash_smac;
  logic [9:0]  w_hash_dmac;
  logic [15:0] w_flood;
  logic [15:0] w_hit_map;

  logic        w_se_source;
  logic [47:0] w_se_mac;
  logic [9:0]  w_se_hash;
  logic [15:0] w_se_portmap;

  assign w_hdr_xfer  = io_bus.hdr_valid & r_hdr_ready;
  assign w_tmo       = (r_tmo_cnt == TmoLast);
  // Ack has priority, so a nak only counts when no ack arrives with it.
  assign w_resp_fail = (io_bus.se_nak & ~io_bus.se_ack) | (~io_bus.se_ack & w_tmo);
  assign w_hash_smac = mac_hash(io_bus.hdr_smac);
  assign w_hash_dmac = mac_hash(io_bus.hdr_dmac);
  assign w_flood     = PORT_MASK & ~r_src_bit;
  assign w_hit_map   = io_bus.se_result & PORT_MASK & ~r_src_bit;

  // Header FSM next state, forwarding result, learn-fail count, response timer.
  always_comb begin
    w_state_nxt       = r_state;
    w_fwd_portmap_nxt = r_fwd_portmap;
    w_fwd_hit_nxt     = r_fwd_hit;
    w_fail_cnt_nxt    = r_fail_cnt;
    w_tmo_cnt_nxt     = 6'd0;

    unique case (r_state)
      StIdle: begin
        if (w_hdr_xfer) begin
          // Group source addresses are never learned.
          w_state_nxt = io_bus.hdr_smac[40] ? StGap : StLearn;
        end
      end
      StLearn: begin
        if (io_bus.se_ack) begin
          w_state_nxt = StGap;
        end else if (w_resp_fail) begin
          w_state_nxt = StGap;
          if (r_fail_cnt != 16'hFFFF) begin
            w_fail_cnt_nxt = r_fail_cnt + 16'd1;
          end
        end
      end
      StGap: begin
        if (r_dmac[40]) begin
          w_state_nxt       = StDone;
          w_fwd_portmap_nxt = w_flood;
          w_fwd_hit_nxt     = 1'b0;
        end else begin
          w_state_nxt = StLookup;
        end
      end
      StLookup: begin
        if (io_bus.se_ack) begin
          // A hit that points only back at the ingress port becomes a drop.
          w_state_nxt       = StDone;
          w_fwd_portmap_nxt = w_hit_map;
          w_fwd_hit_nxt     = 1'b1;
        end else if (w_resp_fail) begin
          w_state_nxt       = StDone;
          w_fwd_portmap_nxt = w_flood;
          w_fwd_hit_nxt     = 1'b0;
        end
      end
      StDone: begin
        w_state_nxt = StIdle;
      end
      default: begin
        w_state_nxt = StIdle;
      end
    endcase

    // Timer counts cycles spent waiting in one request; any state change clears it.
    if (((r_state == StLearn) || (r_state == StLookup)) && (w_state_nxt == r_state)) begin
      w_tmo_cnt_nxt = r_tmo_cnt + 6'd1;
    end
  end

  // FSM state, handshake levels, forwarding result and counters.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state       <= StIdle;
      r_tmo_cnt     <= 6'd0;
      r_se_req      <= 1'b0;
      r_hdr_ready   <= 1'b0;
      r_fwd_valid   <= 1'b0;
      r_fwd_portmap <= 16'd0;
      r_fwd_hit     <= 1'b0;
      r_fail_cnt    <= 16'd0;
    end else begin
      r_state       <= w_state_nxt;
      r_tmo_cnt     <= w_tmo_cnt_nxt;
      r_se_req      <= (w_state_nxt == StLearn) || (w_state_nxt == StLookup);
      r_hdr_ready   <= (w_state_nxt == StIdle);
      r_fwd_valid   <= (w_state_nxt == StDone);
      r_fwd_portmap <= w_fwd_portmap_nxt;
      r_fwd_hit     <= w_fwd_hit_nxt;
      r_fail_cnt    <= w_fail_cnt_nxt;
    end
  end

  // Header capture: MACs, their bucket hashes and the one-hot ingress port.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_dmac    <= 48'd0;
      r_smac    <= 48'd0;
      r_src_bit <= 16'd0;
      r_hash_s  <= 10'd0;
      r_hash_d  <= 10'd0;
    end else if (w_hdr_xfer) begin
      r_dmac    <= io_bus.hdr_dmac;
      r_smac    <= io_bus.hdr_smac;
      r_src_bit <= 16'b1 << io_bus.hdr_port;
      r_hash_s  <= w_hash_smac;
      r_hash_d  <= w_hash_dmac;
    end
  end

  // Request payload, held steady for as long as the request state lasts.
  always_comb begin
    w_se_source  = 1'b0;
    w_se_mac     = 48'd0;
    w_se_hash    = 10'd0;
    w_se_portmap = 16'd0;
    if (r_state == StLearn) begin
      w_se_source  = 1'b1;
      w_se_mac     = r_smac;
      w_se_hash    = r_hash_s;
      w_se_portmap = r_src_bit;
    end else if (r_state == StLookup) begin
      w_se_mac  = r_dmac;
      w_se_hash = r_hash_d;
    end
  end

  // Aging pacer: count idle cycles, then hold the request until the sweep ends.
  always_comb begin
    w_aging_req_nxt = r_aging_req;
    w_age_cnt_nxt   = r_age_cnt;
    if (!r_aging_req) begin
      if (r_age_cnt == AgeLast) begin
        w_aging_req_nxt = 1'b1;
        w_age_cnt_nxt   = 32'd0;
      end else begin
        w_age_cnt_nxt = r_age_cnt + 32'd1;
      end
    end else if (io_bus.aging_ack) begin
      w_aging_req_nxt = 1'b0;
    end
  end

  // Aging pacer registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_aging_req <= 1'b0;
      r_age_cnt   <= 32'd0;
    end else begin
      r_aging_req <= w_aging_req_nxt;
      r_age_cnt   <= w_age_cnt_nxt;
    end
  end

  assign io_bus.hdr_ready      = r_hdr_ready;
  assign io_bus.se_source      = w_se_source;
  assign io_bus.se_mac         = w_se_mac;
  assign io_bus.se_hash        = w_se_hash;
  assign io_bus.se_portmap     = w_se_portmap;
  assign io_bus.se_req         = r_se_req;
  assign io_bus.aging_req      = r_aging_req;
  assign io_bus.fwd_valid      = r_fwd_valid;
  assign io_bus.fwd_portmap    = r_fwd_portmap;
  assign io_bus.fwd_hit        = r_fwd_hit;
  assign io_bus.learn_fail_cnt = r_fail_cnt;

endmodule

// File: tb/tb_hash_lookup_ctrl.sv
// Bench for hash_lookup_ctrl: directed headers against a scripted bucket,
// with a per-cycle checker driven by a request/forwarding model.
module tb_hash_lookup_ctrl;

  localparam logic [15:0] PMASK    = 16'hFFFF;
  localparam int          TMO      = 32;
  localparam int          AGE      = 100;
  localparam int          RESP_DLY = 3;
  localparam int          ACK_DLY  = 6;

  localparam int MAck    = 0;
  localparam int MNak    = 1;
  localparam int MSilent = 2;
  localparam int MBoth   = 3;

  typedef struct {
    bit          learn;
    int          mode;
    logic [47:0] mac;
    logic [9:0]  hash;
    logic [15:0] pmap;
  } req_t;

  logic clk = 1'b0;
  logic rstn = 1'b0;

  hash_lookup_ctrl_if bus ();

  hash_lookup_ctrl #(
    .PORT_MASK   (PMASK),
    .SE_TIMEOUT  (6'd32),
    .AGING_PERIOD(32'd100)
  ) dut (
    .clk   (clk),
    .rstn  (rstn),
    .io_bus(bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;

  req_t        exp_q[$];
  logic [15:0] exp_pm;
  logic        exp_hit;
  int          exp_fail = 0;
  bit          in_flight = 0;
  bit          done = 0;
  int          fwd_cnt = 0;
  bit          had_learn = 0;
  int          cur_lmode = MAck;
  int          cur_kmode = MAck;
  logic [15:0] cur_result = 16'd0;

  logic [15:0] last_pm = 16'd0;
  logic        last_hit = 1'b0;
  logic [9:0]  first_learn_hash = 10'd0;
  bit          got_hash = 0;
  int          first_rise_cyc = -1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Bit i of the MAC lands on hash bit i mod 10.
  function automatic logic [9:0] model_hash(input logic [47:0] m);
    logic [9:0] h;
    h = 10'd0;
    for (int i = 0; i < 48; i++) h[i % 10] = h[i % 10] ^ m[i];
    return h;
  endfunction

  // Scripted bucket: answers each request RESP_DLY cycles after it rises.
  initial begin
    int wcnt;
    bit resp;
    int m;
    wcnt = 0;
    resp = 0;
    bus.se_ack = 1'b0;
    bus.se_nak = 1'b0;
    bus.se_result = 16'd0;
    forever begin
      @(posedge clk);
      #1;
      bus.se_ack = 1'b0;
      bus.se_nak = 1'b0;
      if (!bus.se_req) begin
        wcnt = 0;
        resp = 0;
      end else if (!resp) begin
        wcnt++;
        if (wcnt == RESP_DLY) begin
          resp = 1;
          m = bus.se_source ? cur_lmode : cur_kmode;
          if (m == MAck || m == MBoth) begin
            bus.se_ack = 1'b1;
            bus.se_result = cur_result;
          end
          if (m == MNak || m == MBoth) bus.se_nak = 1'b1;
        end
      end
    end
  end

  // Aging sweep responder: ends each sweep ACK_DLY cycles after it starts.
  initial begin
    int c;
    c = 0;
    bus.aging_ack = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      bus.aging_ack = 1'b0;
      if (bus.aging_req && rstn) begin
        c++;
        if (c == ACK_DLY) bus.aging_ack = 1'b1;
      end else begin
        c = 0;
      end
    end
  end

  // Per-cycle checker against the model.
  initial begin
    bit   exp_age, ack_prev, prev_req, prev_resp, have_cur, rst_prev;
    int   idle_edges, cyc, high_len, low_len, exp_len;
    req_t cur;
    exp_age = 0; ack_prev = 0; prev_req = 0; prev_resp = 0; have_cur = 0; rst_prev = 0;
    idle_edges = 0; cyc = 0; high_len = 0; low_len = 0; exp_len = 0;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        check("rst_se_req", bus.se_req, 1'b0);
        check("rst_aging_req", bus.aging_req, 1'b0);
        check("rst_fwd_valid", bus.fwd_valid, 1'b0);
        check("rst_hdr_ready", bus.hdr_ready, 1'b0);
        exp_age = 0; ack_prev = 0; prev_req = 0; prev_resp = 0; have_cur = 0; rst_prev = 0;
        idle_edges = 0; cyc = 0;
      end else begin
        cyc++;
        // Aging: rise after AGE idle edges, fall on the edge after an ack pulse.
        if (!exp_age) begin
          idle_edges++;
          if (idle_edges == AGE) begin
            exp_age = 1;
            idle_edges = 0;
          end
        end else if (ack_prev) begin
          exp_age = 0;
        end
        check("aging_req", bus.aging_req, exp_age);
        if (bus.aging_req && first_rise_cyc < 0) first_rise_cyc = cyc;
        ack_prev = bus.aging_ack;

        if (rst_prev) check("hdr_ready", bus.hdr_ready, !in_flight);
        if (!in_flight) check("fwd_valid_idle", bus.fwd_valid, 1'b0);

        if (prev_req && prev_resp) check("se_req_drop", bus.se_req, 1'b0);

        if (bus.se_req && !prev_req) begin
          if (exp_q.size() == 0) begin
            check("se_req_unexpected", bus.se_req, 1'b0);
          end else begin
            cur = exp_q.pop_front();
            have_cur = 1;
            if (!cur.learn && had_learn) check("gap_len", low_len, 1);
            if (cur.learn) had_learn = 1;
          end
          high_len = 0;
        end
        if (bus.se_req) begin
          high_len++;
          if (have_cur) begin
            check("se_source", bus.se_source, cur.learn);
            check("se_mac", bus.se_mac, cur.mac);
            check("se_hash", bus.se_hash, cur.hash);
            check("se_portmap", bus.se_portmap, cur.pmap);
          end
          if (bus.se_source && !got_hash) begin
            first_learn_hash = bus.se_hash;
            got_hash = 1;
          end
        end
        if (!bus.se_req && prev_req) begin
          if (have_cur) begin
            exp_len = (cur.mode == MSilent) ? TMO : RESP_DLY;
            check("se_req_len", high_len, exp_len);
          end
          have_cur = 0;
          low_len = 0;
        end
        if (!bus.se_req) low_len++;
        prev_resp = bus.se_ack | bus.se_nak;
        prev_req = bus.se_req;

        if (bus.fwd_valid) begin
          fwd_cnt++;
          check("fwd_portmap", bus.fwd_portmap, exp_pm);
          check("fwd_hit", bus.fwd_hit, exp_hit);
          check("learn_fail_cnt", bus.learn_fail_cnt, exp_fail);
          check("reqs_left", exp_q.size(), 0);
          last_pm = bus.fwd_portmap;
          last_hit = bus.fwd_hit;
          done = 1;
          in_flight = 0;
        end
        rst_prev = 1;
      end
    end
  end

  // Expected requests and forwarding result for one header.
  task automatic prep(input logic [47:0] dmac, input logic [47:0] smac, input logic [3:0] port,
                      input int lmode, input int kmode, input logic [15:0] result);
    logic [15:0] src;
    req_t r;
    src = 16'h1 << port;
    cur_lmode = lmode;
    cur_kmode = kmode;
    cur_result = result;
    exp_q.delete();
    had_learn = 0;
    if (!smac[40]) begin
      r.learn = 1; r.mode = lmode; r.mac = smac; r.hash = model_hash(smac); r.pmap = src;
      exp_q.push_back(r);
      if (lmode == MNak || lmode == MSilent) exp_fail++;
    end
    if (!dmac[40]) begin
      r.learn = 0; r.mode = kmode; r.mac = dmac; r.hash = model_hash(dmac); r.pmap = 16'd0;
      exp_q.push_back(r);
    end
    if (!dmac[40] && (kmode == MAck || kmode == MBoth)) begin
      exp_pm = result & PMASK & ~src;
      exp_hit = 1'b1;
    end else begin
      exp_pm = PMASK & ~src;
      exp_hit = 1'b0;
    end
    fwd_cnt = 0;
    done = 0;
  endtask

  task automatic drive(input logic [47:0] dmac, input logic [47:0] smac, input logic [3:0] port);
    int guard;
    @(posedge clk);
    #1;
    bus.hdr_valid = 1'b1;
    bus.hdr_dmac = dmac;
    bus.hdr_smac = smac;
    bus.hdr_port = port;
    guard = 0;
    while (!bus.hdr_ready && guard < 50) begin
      @(posedge clk);
      #1;
      guard++;
    end
    check("hdr_accept", bus.hdr_ready, 1'b1);
    @(posedge clk);
    #1;
    bus.hdr_valid = 1'b0;
    in_flight = 1;
  endtask

  task automatic send_hdr(input logic [47:0] dmac, input logic [47:0] smac,
                          input logic [3:0] port, input int lmode, input int kmode,
                          input logic [15:0] result);
    int guard;
    prep(dmac, smac, port, lmode, kmode, result);
    drive(dmac, smac, port);
    guard = 0;
    while (!done && guard < 200) begin
      @(posedge clk);
      guard++;
    end
    check("fwd_seen", done, 1'b1);
    repeat (3) @(posedge clk);
    check("fwd_once", fwd_cnt, 1);
    in_flight = 0;
  endtask

  localparam logic [47:0] MacA = 48'h0011_2233_4455;
  localparam logic [47:0] MacB = 48'h00AA_BBCC_DD01;
  localparam logic [47:0] MacC = 48'h0066_7788_99AA;
  localparam logic [47:0] MacD = 48'h00DE_ADBE_EF00;
  localparam logic [47:0] MacE = 48'h0012_3456_789A;
  localparam logic [47:0] MacF = 48'h00F0_F0F0_F0F0;
  localparam logic [47:0] MacG = 48'h0002_0406_0810;
  localparam logic [47:0] MacGrp = 48'h0100_0000_0001;
  localparam logic [47:0] MacBc = 48'hFFFF_FFFF_FFFF;

  initial begin
    int guard;
    bus.hdr_valid = 1'b0;
    bus.hdr_dmac = 48'd0;
    bus.hdr_smac = 48'd0;
    bus.hdr_port = 4'd0;
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    #2 rstn = 1'b1;

    // Unicast learn of A from port 3 (lookup of B misses), then DMAC A from port 5.
    send_hdr(MacB, MacA, 4'd3, MAck, MNak, 16'd0);
    check("t1_learn_hash", first_learn_hash, 10'h2E3);
    check("t1a_pm", last_pm, 16'hFFF7);
    send_hdr(MacA, MacC, 4'd5, MAck, MAck, 16'h0008);
    check("t1_pm", last_pm, 16'h0008);
    check("t1_hit", last_hit, 1'b1);

    // Unknown DMAC from port 2.
    send_hdr(MacD, MacE, 4'd2, MAck, MNak, 16'd0);
    check("t2_pm", last_pm, 16'hFFFB);
    check("t2_hit", last_hit, 1'b0);

    // Broadcast DMAC: learn only, flood.
    send_hdr(MacBc, MacE, 4'd2, MAck, MAck, 16'h1234);
    check("t3_pm", last_pm, 16'hFFFB);
    check("t3_hit", last_hit, 1'b0);

    // Silent bucket on learn: timeout, fail count, lookup still issued.
    send_hdr(MacA, MacF, 4'd7, MSilent, MAck, 16'h0008);
    check("t4_fail_cnt", bus.learn_fail_cnt, 16'd1);
    check("t4_pm", last_pm, 16'h0008);

    // Learn nak plus silent lookup: flood after timeout.
    send_hdr(MacA, MacG, 4'd1, MNak, MSilent, 16'd0);
    check("nak_fail_cnt", bus.learn_fail_cnt, 16'd2);
    check("lookup_tmo_pm", last_pm, 16'hFFFD);

    // Hit that maps only back to the ingress port: drop with hit set.
    send_hdr(MacA, MacG, 4'd3, MAck, MAck, 16'h0008);
    check("drop_pm", last_pm, 16'h0000);
    check("drop_hit", last_hit, 1'b1);

    // Simultaneous ack and nak: ack wins on both requests.
    send_hdr(MacA, MacG, 4'd0, MBoth, MBoth, 16'h00F1);
    check("both_pm", last_pm, 16'h00F0);
    check("both_fail_cnt", bus.learn_fail_cnt, 16'd2);

    // Group SMAC: no learn request.
    send_hdr(MacA, MacGrp, 4'd4, MNak, MAck, 16'h0030);
    check("grp_pm", last_pm, 16'h0020);

    // Aging: first rise 100 cycles after release; traffic completes mid-sweep.
    check("t5_first_rise", first_rise_cyc, 100);
    guard = 0;
    while (!bus.aging_req && guard < 300) begin
      @(posedge clk);
      #1;
      guard++;
    end
    check("t5_sweep_seen", bus.aging_req, 1'b1);
    send_hdr(MacC, MacD, 4'd6, MAck, MAck, 16'h0041);
    check("t5_pm", last_pm, 16'h0001);

    // Reset with a learn request outstanding.
    prep(MacA, MacF, 4'd2, MSilent, MAck, 16'h0008);
    drive(MacA, MacF, 4'd2);
    guard = 0;
    while (!bus.se_req && guard < 20) begin
      @(posedge clk);
      #1;
      guard++;
    end
    check("t6_req_up", bus.se_req, 1'b1);
    repeat (4) @(posedge clk);
    #2 rstn = 1'b0;
    #1;
    check("t6_se_req", bus.se_req, 1'b0);
    check("t6_aging_req", bus.aging_req, 1'b0);
    check("t6_fwd_valid", bus.fwd_valid, 1'b0);
    check("t6_hdr_ready", bus.hdr_ready, 1'b0);
    exp_q.delete();
    in_flight = 0;
    exp_fail = 0;
    repeat (2) @(negedge clk);
    #2 rstn = 1'b1;
    @(negedge clk);
    check("t6_ready_after", bus.hdr_ready, 1'b1);
    check("t6_fail_cnt", bus.learn_fail_cnt, 16'd0);
    send_hdr(MacA, MacC, 4'd5, MAck, MAck, 16'h0008);
    check("t6_recover_pm", last_pm, 16'h0008);

    repeat (5) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
